// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths, defaults, FSM state encoding and FIFO entry
//               type for the instruction fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int              XLEN             = 32;
    localparam int              DEFAULT_DEPTH    = 4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0;

    // Fetch control FSM: BOOT lasts exactly one cycle after reset release.
    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    // One queued instruction: the fetched word and the word address it came from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Sequential word address; wraps naturally from all-ones to zero.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Circular buffer holding fetched {instr, pc} entries with
//               read/write pointers and an occupancy count. Flush clears the
//               pointers and count and wins over push and pop.
// Ports       : clk, reset (async, active-low)
//               i_flush      - discard all entries
//               i_push       - write i_push_entry at the tail
//               i_pop        - retire the head entry
//               o_head       - entry at the read pointer
//               o_count      - number of valid entries (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  fetch_entry_t           i_push_entry,
    input  logic                   i_pop,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    fetch_entry_t       r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // DEPTH is a power of two, so pointer wrap is plain binary overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; the top gates its outputs when the queue is empty.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue
// Description : Sequential instruction prefetcher in front of a synchronous
//               (1-cycle) instruction memory. Fetches are credit-limited so
//               every returning word always finds a free FIFO slot. A
//               redirect flushes the queue, drops the word arriving that
//               cycle and immediately fetches from the new address.
// Ports       : clk, reset (async, active-low)
//               redirect / redirect_pc   - flush and restart fetch
//               imem_en / imem_addr      - memory read request
//               imem_rdata               - read data, one cycle after imem_en
//               instr_valid / instr / instr_pc / instr_ready - core handshake
// Config      : FETCH_BYPASS_EN - when defined, a word arriving into an empty
//               queue is forwarded to the core in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = DEFAULT_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
);

    localparam int               c_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(DEPTH);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic            r_inflight;

    logic [c_CNT_W-1:0] w_count;
    logic [c_CNT_W:0]   w_occupancy;
    logic               w_has_credit;
    logic               w_issue;
    logic               w_empty;
    logic               w_resp_valid;
    logic               w_push;
    logic               w_pop;
    logic               w_valid;
    fetch_entry_t       w_resp_entry;
    fetch_entry_t       w_head;
    fetch_entry_t       w_out_entry;

    // ------------------------------------------------------------------
    // Fetch issue: queued entries plus the word still in the memory pipe
    // must leave room for the new request.
    // ------------------------------------------------------------------
    assign w_occupancy  = {1'b0, w_count} + {{c_CNT_W{1'b0}}, r_inflight};
    assign w_has_credit = (w_occupancy < c_DEPTH);
    assign w_issue      = (r_state == ST_RUN) && (redirect || w_has_credit);

    assign imem_en   = w_issue;
    assign imem_addr = redirect ? redirect_pc : r_fetch_pc;

    // A word arriving in a redirect cycle belongs to the abandoned path.
    assign w_resp_valid = r_inflight && !redirect;
    assign w_resp_entry = '{instr: imem_rdata, pc: r_resp_pc};
    assign w_empty      = (w_count == '0);

`ifdef FETCH_BYPASS_EN
    logic w_bypass;

    assign w_bypass    = w_resp_valid && w_empty;
    assign w_valid     = !redirect && (!w_empty || w_resp_valid);
    assign w_out_entry = w_empty ? w_resp_entry : w_head;
    // A forwarded word consumed immediately never occupies a slot.
    assign w_push      = w_resp_valid && !(w_bypass && instr_ready);
    assign w_pop       = !redirect && !w_empty && instr_ready;
`else
    assign w_valid     = !redirect && !w_empty;
    assign w_out_entry = w_head;
    assign w_push      = w_resp_valid;
    assign w_pop       = w_valid && instr_ready;
`endif

    assign instr_valid = w_valid;
    assign instr       = w_valid ? w_out_entry.instr : '0;
    assign instr_pc    = w_valid ? w_out_entry.pc    : '0;

    // ------------------------------------------------------------------
    // Control FSM and fetch address tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_BOOT;
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= '0;
            r_inflight <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state    <= ST_RUN;
                    r_inflight <= 1'b0;
                    if (redirect) begin
                        r_fetch_pc <= redirect_pc;
                    end
                end
                ST_RUN: begin
                    r_inflight <= w_issue;
                    // imem_addr already selects redirect_pc, so one update
                    // covers both sequential and redirected fetches.
                    if (w_issue) begin
                        r_resp_pc  <= imem_addr;
                        r_fetch_pc <= next_pc(imem_addr);
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_flush      (redirect),
        .i_push       (w_push),
        .i_push_entry (w_resp_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_queue
// Description : Self-checking bench for instr_fetch_queue. The expected
//               instruction stream is the run of consecutive word addresses
//               starting at RESET_PC or at the last redirect target.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_BYPASS_EN
    localparam int          LAT      = 1;
`else
    localparam int          LAT      = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    always #5 clk = ~clk;

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    // Memory content is a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Synchronous instruction memory: data one cycle after the enable.
    always @(posedge clk) begin
        if (imem_en) begin
            imem_rdata <= mem_word(imem_addr);
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected stream from a new start address (reset or redirect).
    task automatic push_stream(input logic [31:0] start);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < 400; i++) begin
            e.pc   = start + 32'(i);
            e.word = mem_word(e.pc);
            exp_q.push_back(e);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: samples on the falling edge, away from the active edge.
    // ------------------------------------------------------------------
    int          since;
    int          fetches;
    int          accepts;
    int          outstanding;
    int          first_en;
    int          first_val;
    bit          armed;
    logic [31:0] exp_fetch_pc;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            check("rst_imem_en",     32'(imem_en),     32'd0);
            check("rst_instr_valid", 32'(instr_valid), 32'd0);
            check("rst_instr",       instr,            32'd0);
            check("rst_instr_pc",    instr_pc,         32'd0);
            since        = 0;
            fetches      = 0;
            accepts      = 0;
            outstanding  = 0;
            first_en     = -1;
            first_val    = -1;
            armed        = 1'b1;
            exp_fetch_pc = RESET_PC;
        end else begin
            since++;
            if (since == 1) begin
                check("boot_no_fetch", 32'(imem_en), 32'd0);
            end
            if (redirect) begin
                check("redir_valid", 32'(instr_valid), 32'd0);
                check("redir_en",    32'(imem_en),     32'd1);
                check("redir_addr",  imem_addr,        redirect_pc);
                exp_fetch_pc = redirect_pc + 32'd1;
                fetches++;
                outstanding  = 1;
                first_en     = since;
                first_val    = -1;
                armed        = 1'b1;
            end else begin
                if (imem_en) begin
                    check("fetch_addr", imem_addr, exp_fetch_pc);
                    exp_fetch_pc = exp_fetch_pc + 32'd1;
                    fetches++;
                    outstanding++;
                    if (first_en < 0) first_en = since;
                    checks++;
                    if (outstanding > DEPTH) begin
                        errors++;
                        $display("FAIL outstanding: got %0d, required <= %0d (t=%0t)",
                                 outstanding, DEPTH, $time);
                    end
                end
                if (instr_valid && armed) begin
                    armed     = 1'b0;
                    first_val = since;
                    check("latency", 32'(first_val - first_en), LAT);
                end
                if (instr_valid && instr_ready) begin
                    accepts++;
                    outstanding--;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow: got pc %h, required none", instr_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("instr_pc", instr_pc, e.pc);
                        check("instr",    instr,    e.word);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic do_reset(input logic ready_after);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        redirect = 1'b0;
        push_stream(RESET_PC);
        repeat (2) @(posedge clk);
        #1;
        reset       = 1'b1;
        instr_ready = ready_after;
    endtask

    task automatic step_redirect(input logic [31:0] pc);
        @(posedge clk);
        #1;
        redirect    = 1'b1;
        redirect_pc = pc;
        push_stream(pc);
        @(posedge clk);
        #1;
        redirect = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        push_stream(RESET_PC);
        #2;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Streaming from reset with the core always ready.
        repeat (12) @(posedge clk);
        check("stream_fetches", 32'(fetches), 32'd11);
        check("stream_accepts", 32'(accepts), 32'(11 - LAT));

        // Redirects while words are arriving, including address wrap.
        step_redirect(32'h0000_0040);
        repeat (6) @(posedge clk);
        step_redirect(32'hFFFF_FFFF);
        repeat (6) @(posedge clk);

        // Core stalled from reset: fetching stops once the queue is committed.
        do_reset(1'b0);
        repeat (12) @(posedge clk);
        check("stall_fetches", 32'(fetches), 32'(DEPTH));
        #1;
        instr_ready = 1'b1;
        repeat (10) @(posedge clk);
        check("stall_drain", 32'(accepts >= DEPTH), 32'd1);

        // Reset with three entries queued and one word in flight.
        do_reset(1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_valid", 32'(instr_valid), 32'd1);
        reset = 1'b0;
        push_stream(RESET_PC);
        #1;
        check("async_rst_valid", 32'(instr_valid), 32'd0);
        check("async_rst_en",    32'(imem_en),     32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset       = 1'b1;
        instr_ready = 1'b1;
        repeat (12) @(posedge clk);
        check("restart_fetches", 32'(fetches), 32'd11);
        check("restart_accepts", 32'(accepts), 32'(11 - LAT));

        // Randomized ready and redirects.
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            instr_ready = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) begin
                redirect    = 1'b1;
                redirect_pc = ($urandom_range(3) == 0) ?
                              (32'hFFFF_FFFF - 32'($urandom_range(2))) : 32'($urandom);
                push_stream(redirect_pc);
            end else begin
                redirect = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        redirect    = 1'b0;
        instr_ready = 1'b1;
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
